// File: rtl/playseq_detector_jogada.sv
// playseq_detector_jogada: button synchroniser, debounce filter and one-hot press detector.
// Build option: define PLAYSEQ_DEBOUNCE_EN to include the FILTRA/SOLTA debounce states.
module playseq_detector_jogada #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    output logic                tem_jogada,
    output logic [N_BOTOES-1:0] jogada,
    output logic                invalida,
    output logic [2:0]          db_estado
);

    localparam logic [2:0] OCIOSO = 3'd0;
    localparam logic [2:0] PULSO  = 3'd2;
    localparam logic [2:0] SEGURA = 3'd3;
`ifdef PLAYSEQ_DEBOUNCE_EN
    localparam logic [2:0] FILTRA = 3'd1;
    localparam logic [2:0] SOLTA  = 3'd4;
`endif

    logic [N_BOTOES-1:0] s1_q;
    logic [N_BOTOES-1:0] s2_q;
    logic [N_BOTOES-1:0] amostra_q;
    logic [N_BOTOES-1:0] amostra_d;
    logic [N_BOTOES-1:0] jogada_q;
    logic [N_BOTOES-1:0] jogada_d;
    logic [2:0]          estado_q;
    logic [2:0]          estado_d;
    logic                tem_jogada_q;
    logic                tem_jogada_d;
    logic                invalida_q;
    logic                invalida_d;
    logic                s2_ativo;
    logic                s2_um_quente;

    assign s2_ativo     = |s2_q;
    assign s2_um_quente = s2_ativo
                       && ((s2_q & (s2_q - N_BOTOES'(1))) == '0);

`ifdef PLAYSEQ_DEBOUNCE_EN
    localparam logic [7:0] CONTA_FIM = 8'(DEBOUNCE_CICLOS - 1);

    logic [7:0] conta_q;
    logic [7:0] conta_d;
    logic       conta_fim;

    assign conta_fim = (conta_q == CONTA_FIM);
`else
    logic [7:0] unused_debounce;

    assign unused_debounce = 8'(DEBOUNCE_CICLOS);
`endif

    always_comb begin
        estado_d     = estado_q;
        amostra_d    = amostra_q;
        jogada_d     = jogada_q;
        tem_jogada_d = 1'b0;
        invalida_d   = 1'b0;
`ifdef PLAYSEQ_DEBOUNCE_EN
        conta_d      = conta_q;

        case (estado_q)
            OCIOSO: begin
                if (s2_ativo) begin
                    if (habilita) begin
                        amostra_d = s2_q;
                        conta_d   = 8'd0;
                        estado_d  = FILTRA;
                    end else begin
                        estado_d  = SEGURA;
                    end
                end
            end
            FILTRA: begin
                if (!habilita) begin
                    estado_d = SEGURA;
                end else if (!s2_ativo) begin
                    estado_d = OCIOSO;
                end else if (s2_q != amostra_q) begin
                    // a pattern change restarts the stability window
                    amostra_d = s2_q;
                    conta_d   = 8'd0;
                end else if (conta_fim) begin
                    if (s2_um_quente) begin
                        estado_d   = PULSO;
                    end else begin
                        invalida_d = 1'b1;
                        estado_d   = SEGURA;
                    end
                end else begin
                    conta_d = conta_q + 8'd1;
                end
            end
            PULSO: begin
                estado_d = SEGURA;
            end
            SEGURA: begin
                if (!s2_ativo) begin
                    conta_d  = 8'd0;
                    estado_d = SOLTA;
                end
            end
            SOLTA: begin
                if (s2_ativo) begin
                    estado_d = SEGURA;
                end else if (conta_fim) begin
                    estado_d = OCIOSO;
                end else begin
                    conta_d = conta_q + 8'd1;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
`else
        case (estado_q)
            OCIOSO: begin
                if (s2_ativo) begin
                    if (!habilita) begin
                        estado_d   = SEGURA;
                    end else if (s2_um_quente) begin
                        amostra_d  = s2_q;
                        estado_d   = PULSO;
                    end else begin
                        invalida_d = 1'b1;
                        estado_d   = SEGURA;
                    end
                end
            end
            PULSO: begin
                estado_d = SEGURA;
            end
            SEGURA: begin
                if (!s2_ativo) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
`endif

        // outputs are registered alongside the state they belong to
        if (estado_d == PULSO) begin
            tem_jogada_d = 1'b1;
            jogada_d     = amostra_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            amostra_q    <= '0;
            jogada_q     <= '0;
            estado_q     <= OCIOSO;
            tem_jogada_q <= 1'b0;
            invalida_q   <= 1'b0;
        end else begin
            s1_q         <= botoes;
            s2_q         <= s1_q;
            amostra_q    <= amostra_d;
            jogada_q     <= jogada_d;
            estado_q     <= estado_d;
            tem_jogada_q <= tem_jogada_d;
            invalida_q   <= invalida_d;
        end
    end

`ifdef PLAYSEQ_DEBOUNCE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            conta_q <= 8'd0;
        end else begin
            conta_q <= conta_d;
        end
    end
`endif

    assign tem_jogada = tem_jogada_q;
    assign jogada     = jogada_q;
    assign invalida   = invalida_q;
    assign db_estado  = estado_q;

endmodule

// File: tb/tb_playseq_detector_jogada.sv
// Testbench for playseq_detector_jogada: directed scenarios plus random presses
// checked every cycle against a behavioural model of the press detector.
module tb_playseq_detector_jogada;

    localparam int NB = 4;
    localparam int DB = 4;

    localparam int ST_OCIOSO = 0;
    localparam int ST_FILTRA = 1;
    localparam int ST_PULSO  = 2;
    localparam int ST_SEGURA = 3;
    localparam int ST_SOLTA  = 4;

`ifdef PLAYSEQ_DEBOUNCE_EN
    localparam int LAT       = 2 + DB;
    localparam int N_BOUNCE  = 1;
    localparam int N_RST     = 0;
    localparam int N_REPRESS = 1;
`else
    localparam int LAT       = 2;
    localparam int N_BOUNCE  = 2;
    localparam int N_RST     = 1;
    localparam int N_REPRESS = 2;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [NB-1:0] botoes;
    logic          habilita;
    logic          tem_jogada;
    logic [NB-1:0] jogada;
    logic          invalida;
    logic [2:0]    db_estado;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_pulse = 0;
    int n_inv = 0;
    int last_pulse = -1;
    bit chk_en = 1'b0;

    logic [NB-1:0] m_s1 = '0;
    logic [NB-1:0] m_s2 = '0;
    logic [NB-1:0] m_am = '0;
    logic [NB-1:0] m_jog = '0;
    int            m_st = 0;
    int            m_cnt = 0;
    logic          m_tj = 1'b0;
    logic          m_inv = 1'b0;

    always #5 clock = ~clock;

    playseq_detector_jogada #(
        .N_BOTOES        (NB),
        .DEBOUNCE_CICLOS (DB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .botoes     (botoes),
        .habilita   (habilita),
        .tem_jogada (tem_jogada),
        .jogada     (jogada),
        .invalida   (invalida),
        .db_estado  (db_estado)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: stable-sample counting in the filter and release windows
    always @(posedge clock) begin : model
        logic [NB-1:0] s2v;
        logic [NB-1:0] am;
        logic [NB-1:0] jg;
        int            st;
        int            cnt;
        logic          tj;
        logic          inv;
        s2v = m_s2;
        am  = m_am;
        jg  = m_jog;
        st  = m_st;
        cnt = m_cnt;
        tj  = 1'b0;
        inv = 1'b0;
        if (reset) begin
            am  = '0;
            jg  = '0;
            st  = ST_OCIOSO;
            cnt = 0;
        end else begin
`ifdef PLAYSEQ_DEBOUNCE_EN
            case (st)
                ST_OCIOSO: if (s2v != 0) begin
                    if (habilita) begin
                        am  = s2v;
                        cnt = 0;
                        st  = ST_FILTRA;
                    end else begin
                        st  = ST_SEGURA;
                    end
                end
                ST_FILTRA: if (!habilita) begin
                    st = ST_SEGURA;
                end else if (s2v == 0) begin
                    st = ST_OCIOSO;
                end else if (s2v != am) begin
                    am  = s2v;
                    cnt = 0;
                end else begin
                    cnt = cnt + 1;
                    if (cnt == DB) begin
                        if ($countones(am) == 1) begin
                            st = ST_PULSO;
                        end else begin
                            inv = 1'b1;
                            st  = ST_SEGURA;
                        end
                    end
                end
                ST_PULSO: st = ST_SEGURA;
                ST_SEGURA: if (s2v == 0) begin
                    cnt = 0;
                    st  = ST_SOLTA;
                end
                ST_SOLTA: if (s2v != 0) begin
                    st = ST_SEGURA;
                end else begin
                    cnt = cnt + 1;
                    if (cnt == DB) st = ST_OCIOSO;
                end
                default: st = ST_OCIOSO;
            endcase
`else
            case (st)
                ST_OCIOSO: if (s2v != 0) begin
                    if (!habilita) begin
                        st = ST_SEGURA;
                    end else if ($countones(s2v) == 1) begin
                        am = s2v;
                        st = ST_PULSO;
                    end else begin
                        inv = 1'b1;
                        st  = ST_SEGURA;
                    end
                end
                ST_PULSO: st = ST_SEGURA;
                ST_SEGURA: if (s2v == 0) st = ST_OCIOSO;
                default: st = ST_OCIOSO;
            endcase
`endif
            if (st == ST_PULSO) begin
                tj = 1'b1;
                jg = am;
            end
        end
        m_s1  <= reset ? '0 : botoes;
        m_s2  <= reset ? '0 : m_s1;
        m_am  <= am;
        m_jog <= jg;
        m_st  <= st;
        m_cnt <= cnt;
        m_tj  <= tj;
        m_inv <= inv;
        cyc   <= cyc + 1;
    end

    always @(negedge clock) begin
        if (tem_jogada === 1'b1) begin
            n_pulse    <= n_pulse + 1;
            last_pulse <= cyc;
        end
        if (invalida === 1'b1) n_inv <= n_inv + 1;
        if (chk_en) begin
            check("tem_jogada", 32'(tem_jogada), 32'(m_tj));
            check("invalida", 32'(invalida), 32'(m_inv));
            check("jogada", 32'(jogada), 32'(m_jog));
            check("db_estado", 32'(db_estado), 32'(m_st));
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic rest(input int n);
        botoes = '0;
        repeat (n) step();
    endtask

    initial begin
        int np0;
        int ni0;
        int e;
        int r;
        int hold;
        logic [NB-1:0] one;
        logic [NB-1:0] pat;

        one      = 4'b0001;
        reset    = 1'b1;
        habilita = 1'b1;
        botoes   = '0;
        step();
        step();
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_estado", 32'(db_estado), 32'd0);
        check("rst_jogada", 32'(jogada), 32'd0);
        check("rst_tem", 32'(tem_jogada), 32'd0);
        check("rst_inv", 32'(invalida), 32'd0);

        // single press
        np0 = n_pulse;
        e = cyc + 1;
        botoes = 4'b0100;
        repeat (20) step();
        check("single_count", 32'(n_pulse - np0), 32'd1);
        check("single_time", 32'(last_pulse), 32'(e + LAT));
        check("single_jogada", 32'(jogada), 32'b0100);
        rest(12);
        check("single_hold", 32'(jogada), 32'b0100);

        // bounce
        np0 = n_pulse;
        botoes = 4'b0001;
        repeat (2) step();
        botoes = 4'b0000;
        repeat (2) step();
        e = cyc + 1;
        botoes = 4'b0001;
        repeat (16) step();
        check("bounce_count", 32'(n_pulse - np0), 32'(N_BOUNCE));
        check("bounce_time", 32'(last_pulse), 32'(e + LAT));
        check("bounce_jogada", 32'(jogada), 32'b0001);
        rest(12);

        // multi-button press
        np0 = n_pulse;
        ni0 = n_inv;
        botoes = 4'b0011;
        repeat (10) step();
        check("multi_inv", 32'(n_inv - ni0), 32'd1);
        check("multi_pulse", 32'(n_pulse - np0), 32'd0);
        check("multi_jogada", 32'(jogada), 32'b0001);
        rest(12);

        // gating by habilita
        np0 = n_pulse;
        habilita = 1'b0;
        botoes = 4'b1000;
        repeat (4) step();
        habilita = 1'b1;
        repeat (6) step();
        check("gate_nopulse", 32'(n_pulse - np0), 32'd0);
        rest(6);
        e = cyc + 1;
        botoes = 4'b1000;
        repeat (12) step();
        check("gate_count", 32'(n_pulse - np0), 32'd1);
        check("gate_time", 32'(last_pulse), 32'(e + LAT));
        check("gate_jogada", 32'(jogada), 32'b1000);
        rest(12);

        // reset while filtering
        np0 = n_pulse;
        botoes = 4'b0100;
        repeat (4) step();
        reset = 1'b1;
        botoes = '0;
        step();
        reset = 1'b0;
        check("rstmid_estado", 32'(db_estado), 32'd0);
        check("rstmid_jogada", 32'(jogada), 32'd0);
        rest(10);
        check("rstmid_pulses", 32'(n_pulse - np0), 32'(N_RST));

        // short release then re-press
        np0 = n_pulse;
        e = cyc + 1;
        botoes = 4'b0010;
        repeat (8) step();
        check("repress_first", 32'(last_pulse), 32'(e + LAT));
        botoes = '0;
        step();
        botoes = 4'b0010;
        repeat (8) step();
        check("repress_count", 32'(n_pulse - np0), 32'(N_REPRESS));
        check("repress_jogada", 32'(jogada), 32'b0010);
        rest(12);

        // random presses, glitches, gating and resets
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 9);
            if (r < 6) pat = one << $urandom_range(0, NB - 1);
            else if (r < 8) pat = '0;
            else pat = NB'($urandom_range(1, 15));
            botoes   = pat;
            habilita = ($urandom_range(0, 9) != 0);
            reset    = ($urandom_range(0, 49) == 0);
            hold     = $urandom_range(1, 14);
            repeat (hold) begin
                step();
                reset = 1'b0;
            end
        end
        habilita = 1'b1;
        rest(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/playseq_detector_jogada.md
# playseq_detector_jogada

Input-conditioning stage of the PlaySeq game, directly upstream of the control unit. Synchronises and debounces the player buttons and emits a single-cycle `tem_jogada` pulse per valid press, together with the one-hot code `jogada` consumed by the datapath register. Multi-button presses are rejected and flagged. A held button never produces more than one pulse.

## Interface
- `N_BOTOES`, default 4: number of buttons, which is also the width of `botoes` and `jogada`.
- `DEBOUNCE_CICLOS`, default 4: consecutive stable cycles required. Legal range 1..255. The counter is 8 bits wide.
- `clock` in 1: system clock. Only rising edges are used.
- `reset` in 1: synchronous, active-high reset.
- `botoes` in N_BOTOES: raw asynchronous button levels, 1 = pressed.
- `habilita` in 1: accept presses when 1.
- `tem_jogada` out 1: one-cycle pulse marking a valid press.
- `jogada` out N_BOTOES: one-hot code of the last valid press. Held until the next valid press.
- `invalida` out 1: one-cycle pulse when a stable multi-button press is rejected.
- `db_estado` out 3: current FSM state, for the debug display.

## Operation
- **Synchroniser:** two flops, `s1` then `s2`. All logic below uses `s2` only.
- **Reset** (on the clock edge with `reset`=1):
  - FSM goes to OCIOSO; counter, `amostra`, `s1` and `s2` go to 0.
  - Outputs go to `tem_jogada`=0, `jogada`=0, `invalida`=0, `db_estado`=0.
  - `reset` overrides every other input.
- **FSM states** (`db_estado` value in brackets):
  - **OCIOSO** [0]:
    - If `habilita`=1 and `s2`≠0: latch `amostra`←`s2`, set count←0, go to FILTRA.
    - If `habilita`=0 and `s2`≠0: go to SEGURA.
  - **FILTRA** [1]:
    - If `habilita`=0: go to SEGURA.
    - Else if `s2`=0: go to OCIOSO.
    - Else if `s2`≠`amostra`: set `amostra`←`s2`, count←0, stay in FILTRA.
    - Else increment count. When count reaches DEBOUNCE_CICLOS−1 on a stable sample:
      - if `amostra` is one-hot, go to PULSO;
      - otherwise pulse `invalida` and go to SEGURA.
  - **PULSO** [2]: `tem_jogada`=1 and `jogada`←`amostra`, then unconditionally go to SEGURA.
  - **SEGURA** [3]: wait for release. If `s2`=0, set count←0 and go to SOLTA.
  - **SOLTA** [4]:
    - If `s2`≠0: go to SEGURA.
    - Else increment count. At DEBOUNCE_CICLOS−1, go to OCIOSO.
  - Unused encodings 5–7 go to OCIOSO.
- **Output rules:**
  - `tem_jogada` and `invalida` are registered Moore outputs and are never high together.
  - `jogada` changes only on the edge entering PULSO.
- **Simultaneous events:** a new button added during FILTRA restarts the filter with the new pattern. If that pattern is multi-hot, it leads to `invalida` and no pulse.
- **`habilita` deasserted mid-press:** no pulse is produced. The button must be released and pressed again.

## Timing
- With a press held stable from edge E (first edge sampling it into `s1`):
  - `s2`≠0 after E+1;
  - FILTRA entered at E+2;
  - PULSO entered at E+2+DEBOUNCE_CICLOS.
  - `tem_jogada` is high for exactly one cycle after that edge.
- Re-arm after release: `s2`=0 at R+1, SOLTA entered at R+2, OCIOSO at R+2+DEBOUNCE_CICLOS. The earliest next press is accepted thereafter.
- Glitches shorter than DEBOUNCE_CICLOS cycles never produce `tem_jogada`.
- The control unit samples `tem_jogada` in its wait state. The single-cycle pulse width is guaranteed, so no handshake back from the control unit is required.

## Configuration
- Macro `PLAYSEQ_DEBOUNCE_EN`:
  - **Defined:** behaviour exactly as above.
  - **Undefined:**
    - FILTRA and SOLTA are not built.
    - OCIOSO goes straight to PULSO, or to SEGURA with `invalida` for a multi-hot `s2`.
    - SEGURA returns to OCIOSO on the first `s2`=0.
    - `DEBOUNCE_CICLOS` is ignored. Press-to-pulse latency is PULSO entered at E+2.

## Test plan
- **Single press:** `DEBOUNCE_CICLOS`=4, `habilita`=1, `botoes`=0100 held 20 cycles → one `tem_jogada` pulse, with PULSO entered at E+6. `jogada`=0100 until the next press.
- **Bounce:** toggle `botoes`=0001 for 0001/0000/0001 at 2-cycle intervals, then hold → exactly one pulse, issued 4 stable cycles after the last toggle. `jogada`=0001.
- **Multi-press:** `botoes`=0011 held 10 cycles → one `invalida` pulse, no `tem_jogada`. `jogada` keeps its prior value.
- **Gating:** press 1000 with `habilita`=0, raise `habilita` while still held → no pulse. Release 6 cycles, press 1000 again → one pulse.
- **Reset mid-filter:** assert `reset` while in FILTRA → next cycle `db_estado`=0, `jogada`=0000, no pulse.
- **Macro off:** `PLAYSEQ_DEBOUNCE_EN` undefined, `botoes`=0010 → PULSO entered at E+2. A 1-cycle release followed by a re-press yields a second pulse.
